key_debounce_array: RTL and testbench

Parametrised N-channel successor to the single-shot button edge detector. Synchronises raw push-button inputs to CLK_50M and debounces each channel by requiring a configurable number of consecutive agreeing samples. Per channel it produces a clean level plus one-cycle press, release and auto-repeat (typematic) pulses. Sits between the board buttons and the game control FSM (snake direction, menu navigation).

---
 rtl/key_debounce_array.sv | 139 +++++++++++++
 tb/tb_key_debounce_array.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_array.sv
// N-channel push-button synchroniser and debouncer.
// Emits clean levels plus press, release and typematic repeat pulses.
module key_debounce_array #(
  parameter int N_KEYS       = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter bit ACTIVE_HIGH  = 1'b1
) (
  input  logic              CLK_50M,
  input  logic              RSTn,
  input  logic [N_KEYS-1:0] key_in,
  input  logic              repeat_en,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] repeat_pulse,
  output logic              any_press
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STABLE_TICKS + 1);
  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);

  localparam logic [N_KEYS-1:0] IDLE_RAW =
    {N_KEYS{~ACTIVE_HIGH}};
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(STABLE_TICKS - 1);
  localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_RATE = RW'(REPEAT_RATE);
  localparam logic [RW-1:0] R_ONE = RW'(1);

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] s;
  logic [TW-1:0]     tick_cnt;
  logic              tick;

  logic [SW-1:0] stable_cnt [N_KEYS];
  logic [SW-1:0] stab_d     [N_KEYS];
  logic [RW-1:0] rep_cnt    [N_KEYS];
  logic [RW-1:0] rep_d      [N_KEYS];

  logic [N_KEYS-1:0] lvl_d;
  logic [N_KEYS-1:0] prs_d;
  logic [N_KEYS-1:0] rel_d;
  logic [N_KEYS-1:0] rpt_d;

  // Two-flop synchroniser, reset to the released raw level.
  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      sync1 <= IDLE_RAW;
      sync2 <= IDLE_RAW;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ IDLE_RAW;

  // Free-running sample tick divider.
  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Per-channel debounce decision and repeat countdown.
  always_comb begin
    lvl_d = key_level;
    prs_d = '0;
    rel_d = '0;
    rpt_d = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      stab_d[i] = stable_cnt[i];
      rep_d[i]  = rep_cnt[i];
    end
    if (tick) begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (s[i] == key_level[i]) begin
          stab_d[i] = '0;
        end else if (stable_cnt[i] == ST_LAST) begin
          lvl_d[i]  = s[i];
          stab_d[i] = '0;
          prs_d[i]  = s[i];
          rel_d[i]  = ~s[i];
        end else begin
          stab_d[i] = stable_cnt[i] + 1'b1;
        end
        if (prs_d[i]) begin
          rep_d[i] = repeat_en ? R_DELAY : '0;
        end else if (!lvl_d[i] || !repeat_en) begin
          rep_d[i] = '0;
        end else if (rep_cnt[i] == R_ONE) begin
          rpt_d[i] = 1'b1;
          rep_d[i] = R_RATE;
        end else if (rep_cnt[i] != '0) begin
          rep_d[i] = rep_cnt[i] - 1'b1;
        end
      end
    end
  end

  // Channel state and registered one-cycle pulses.
  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      key_level     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      repeat_pulse  <= '0;
      any_press     <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
        stable_cnt[i] <= '0;
        rep_cnt[i]    <= '0;
      end
    end else begin
      key_level     <= lvl_d;
      press_pulse   <= prs_d;
      release_pulse <= rel_d;
      repeat_pulse  <= rpt_d;
      any_press     <= |prs_d;
      for (int i = 0; i < N_KEYS; i++) begin
        stable_cnt[i] <= stab_d[i];
        rep_cnt[i]    <= rep_d[i];
      end
    end
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Scoreboard bench for key_debounce_array.
// Drives an active-high and an active-low instance from one stimulus.
module tb_key_debounce_array;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic         CLK_50M = 1'b0;
  logic         RSTn = 1'b0;
  logic [N-1:0] key_in = '0;
  logic [N-1:0] key_n;
  logic         repeat_en = 1'b0;

  logic [N-1:0] lvl_a, prs_a, rel_a, rpt_a;
  logic         any_a;
  logic [N-1:0] lvl_b, prs_b, rel_b, rpt_b;
  logic         any_b;

  assign key_n = ~key_in;

  always #5 CLK_50M = ~CLK_50M;

  key_debounce_array #(
    .N_KEYS(N), .TICK_DIV(TD), .STABLE_TICKS(ST),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .ACTIVE_HIGH(1'b1)
  ) dut_a (
    .CLK_50M(CLK_50M), .RSTn(RSTn), .key_in(key_in),
    .repeat_en(repeat_en), .key_level(lvl_a),
    .press_pulse(prs_a), .release_pulse(rel_a),
    .repeat_pulse(rpt_a), .any_press(any_a)
  );

  key_debounce_array #(
    .N_KEYS(N), .TICK_DIV(TD), .STABLE_TICKS(ST),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .ACTIVE_HIGH(1'b0)
  ) dut_b (
    .CLK_50M(CLK_50M), .RSTn(RSTn), .key_in(key_n),
    .repeat_en(repeat_en), .key_level(lvl_b),
    .press_pulse(prs_b), .release_pulse(rel_b),
    .repeat_pulse(rpt_b), .any_press(any_b)
  );

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic [N-1:0] rpt;
    logic         any;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   printed = 0;

  // Reference model: history of pressed samples, run lengths of
  // disagreeing ticks, and tick count since each press.
  int           n_edge;
  logic [N-1:0] m_lvl;
  logic [N-1:0] kp1, kp2;
  int           run   [N];
  int           since [N];
  bit           rep_on[N];

  task automatic model_reset();
    n_edge = 0;
    m_lvl  = '0;
    kp1    = '0;
    kp2    = '0;
    for (int i = 0; i < N; i++) begin
      run[i]    = 0;
      since[i]  = 0;
      rep_on[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic rn, input logic [N-1:0] k,
                            input logic en, output exp_t e);
    e = '0;
    if (!rn) begin
      model_reset();
    end else begin
      if ((n_edge % TD) == TD - 1) begin
        for (int i = 0; i < N; i++) begin
          logic smp;
          logic p;
          smp = kp2[i];
          p   = 1'b0;
          if (smp == m_lvl[i]) begin
            run[i] = 0;
          end else begin
            run[i]++;
            if (run[i] == ST) begin
              m_lvl[i] = smp;
              run[i]   = 0;
              p        = smp;
              e.prs[i] = smp;
              e.rel[i] = ~smp;
            end
          end
          if (p) begin
            since[i]  = 0;
            rep_on[i] = en;
          end else if (!m_lvl[i] || !en) begin
            rep_on[i] = 1'b0;
          end else if (rep_on[i]) begin
            since[i]++;
            if (since[i] >= RD && ((since[i] - RD) % RR) == 0)
              e.rpt[i] = 1'b1;
          end
        end
      end
      e.lvl = m_lvl;
      e.any = |e.prs;
      kp2 = kp1;
      kp1 = k;
      n_edge++;
    end
  endtask

  task automatic step(input logic rn, input logic [N-1:0] k,
                      input logic en);
    exp_t e;
    @(posedge CLK_50M);
    model_edge(RSTn, key_in, repeat_en, e);
    #1;
    if (!rn) begin
      model_reset();
      e = '0;
    end
    sb_q.push_back(e);
    RSTn      = rn;
    key_in    = k;
    repeat_en = en;
  endtask

  task automatic hold(input logic [N-1:0] k, input logic en,
                      input int cycles);
    for (int c = 0; c < cycles; c++) step(1'b1, k, en);
  endtask

  task automatic check(input string tag, input exp_t act,
                       input exp_t req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      if (printed < 20) begin
        printed++;
        $display("FAIL %s t=%0t lvl/prs/rel/rpt/any got %h want %h",
                 tag, $time, act, req);
      end
    end
  endtask

  // Monitor: compare each registered output set against the queue.
  always @(negedge CLK_50M) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("ah1", {lvl_a, prs_a, rel_a, rpt_a, any_a}, mon_e);
      check("ah0", {lvl_b, prs_b, rel_b, rpt_b, any_b}, mon_e);
    end
  end

  initial begin
    logic [N-1:0] k;
    logic         en;
    model_reset();
    for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b0);
    hold(4'b0000, 1'b0, 10);
    hold(4'b0001, 1'b0, 40);
    hold(4'b0011, 1'b0, 8);
    hold(4'b0001, 1'b0, 4);
    hold(4'b0011, 1'b0, 20);
    hold(4'b0000, 1'b0, 24);
    hold(4'b0100, 1'b1, 100);
    hold(4'b0000, 1'b1, 24);
    hold(4'b0100, 1'b0, 100);
    hold(4'b0000, 1'b0, 24);
    hold(4'b0100, 1'b0, 24);
    hold(4'b0100, 1'b1, 48);
    hold(4'b0000, 1'b1, 24);
    hold(4'b1111, 1'b0, 30);
    hold(4'b0000, 1'b0, 24);
    hold(4'b1000, 1'b1, 30);
    for (int c = 0; c < 3; c++) step(1'b0, 4'b1000, 1'b1);
    hold(4'b1000, 1'b1, 40);
    hold(4'b0000, 1'b1, 24);
    k  = '0;
    en = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 23) == 0) k[i] = ~k[i];
      if ($urandom_range(0, 199) == 0) en = ~en;
      if ($urandom_range(0, 1999) == 0) begin
        step(1'b0, k, en);
        step(1'b0, k, en);
      end else begin
        step(1'b1, k, en);
      end
    end
    repeat (2) @(negedge CLK_50M);
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain queue left %0d want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
